// File: rtl/vc_pop_arbiter.sv
// Weighted two-VC pop arbiter feeding destination FIFOs D0/D1.
// Pops are combinational; destination pushes and data are registered one cycle later.
module vc_pop_arbiter #(
  parameter int DATA_W     = 6,
  parameter int WEIGHT_VC0 = 4,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              active_in,
  input  logic              FIFO_error,
  input  logic              vc0_empty,
  input  logic              vc1_empty,
  input  logic [DATA_W-1:0] vc0_data,
  input  logic [DATA_W-1:0] vc1_data,
  input  logic              d0_almost_full,
  input  logic              d1_almost_full,
  output logic              vc0_pop,
  output logic              vc1_pop,
  output logic              d0_push,
  output logic              d1_push,
  output logic [DATA_W-1:0] d_data,
  output logic [1:0]        arb_state,
  output logic [CNT_W-1:0]  fwd_count
);

  localparam int unsigned WC_W = $clog2(WEIGHT_VC0 + 1);
  localparam logic [WC_W-1:0] WMAX = WC_W'(WEIGHT_VC0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_ERROR = 2'b10
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [WC_W-1:0]     r_wcnt;
  logic                r_d0_push;
  logic                r_d1_push;
  logic [DATA_W-1:0]   r_d_data;
  logic [CNT_W-1:0]    r_fwd_count;

  logic                w_pop_en;
  logic                w_elig0;
  logic                w_elig1;
  logic                w_gnt0;
  logic                w_gnt1;
  logic                w_any;
  logic [DATA_W-1:0]   w_word;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (FIFO_error) w_state_nxt = S_ERROR;
               else if (active_in) w_state_nxt = S_RUN;
      S_RUN:   if (FIFO_error) w_state_nxt = S_ERROR;
               else if (!active_in) w_state_nxt = S_IDLE;
      S_ERROR: w_state_nxt = S_ERROR;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Pop only while RUN and staying in RUN, so the exit cycle issues no new pop.
  always_comb begin
    w_pop_en = (r_state == S_RUN) && active_in && !FIFO_error;
    w_elig0  = !vc0_empty && !(vc0_data[DATA_W-1] ? d1_almost_full : d0_almost_full);
    w_elig1  = !vc1_empty && !(vc1_data[DATA_W-1] ? d1_almost_full : d0_almost_full);
    w_gnt0   = w_pop_en && w_elig0 && (!w_elig1 || (r_wcnt != WMAX));
    w_gnt1   = w_pop_en && w_elig1 && (!w_elig0 || (r_wcnt == WMAX));
    w_any    = w_gnt0 || w_gnt1;
    w_word   = w_gnt1 ? vc1_data : vc0_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_wcnt      <= '0;
      r_d0_push   <= 1'b0;
      r_d1_push   <= 1'b0;
      r_d_data    <= '0;
      r_fwd_count <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_d0_push <= w_any && !w_word[DATA_W-1];
      r_d1_push <= w_any &&  w_word[DATA_W-1];
      if (w_any) begin
        r_d_data    <= w_word;
        r_fwd_count <= r_fwd_count + 1'b1;
      end
      if (w_gnt1)
        r_wcnt <= '0;
      else if (w_gnt0 && (r_wcnt != WMAX))
        r_wcnt <= r_wcnt + 1'b1;
    end
  end

  assign vc0_pop   = w_gnt0;
  assign vc1_pop   = w_gnt1;
  assign d0_push   = r_d0_push;
  assign d1_push   = r_d1_push;
  assign d_data    = r_d_data;
  assign arb_state = r_state;
  assign fwd_count = r_fwd_count;

endmodule
